// File: rtl/gpio_bank_pkg.sv
// Shared register map and interrupt-type encoding for the GPIO bank.
package gpio_bank_pkg;

    localparam logic [4:0] GPIO_DIR_ADDR   = 5'h00;
    localparam logic [4:0] GPIO_OUT_ADDR   = 5'h04;
    localparam logic [4:0] GPIO_IN_ADDR    = 5'h08;
    localparam logic [4:0] GPIO_IEN_ADDR   = 5'h0C;
    localparam logic [4:0] GPIO_ITYPE_ADDR = 5'h10;
    localparam logic [4:0] GPIO_IPOL_ADDR  = 5'h14;
    localparam logic [4:0] GPIO_ISTAT_ADDR = 5'h18;
    localparam logic [4:0] GPIO_DBT_ADDR   = 5'h1C;

    typedef enum logic {
        INT_LEVEL = 1'b0,
        INT_EDGE  = 1'b1
    } int_type_e;

    // Byte address to word-aligned register address (low two bits dropped).
    function automatic logic [4:0] word_addr(input logic [4:0] a);
        return {a[4:2], 2'b00};
    endfunction

endpackage

// File: rtl/gpio_bank_ctrl_if.sv
// APB register bus between the fabric (master) and the GPIO bank (slave).
interface gpio_bank_ctrl_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    modport master (output psel, penable, pwrite, paddr, pwdata,
                    input  prdata, pready);
    modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                    output prdata, pready);
endinterface

// File: rtl/gpio_pin_debounce.sv
// One pin of the input path: metastability synchroniser followed by a
// counter-based debouncer that only accepts a level held for thresh+1 cycles.
module gpio_pin_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pin_in,
    input  logic [DB_CNT_W-1:0] thresh,
    output logic                stable
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_CNT_W-1:0]    cnt;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    // Shift the raw pad level through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
    end

    // Count cycles of disagreement; accept the new level once the count hits
    // the threshold. Threshold changes are not a reason to restart the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt == thresh) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + DB_CNT_W'(1);
        end
    end

endmodule

// File: rtl/gpio_bank_ctrl.sv
// GPIO bank: APB register file, per-pin debounced inputs, edge/level
// interrupt detection and a single registered interrupt line.
module gpio_bank_ctrl
    import gpio_bank_pkg::*;
#(
    parameter int GPIO_DATA_WIDTH = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DB_CNT_W        = 8
) (
    input  logic                       pclk,
    input  logic                       p_reset,
    gpio_bank_ctrl_if.slave            apb,
    input  logic [GPIO_DATA_WIDTH-1:0] gpio_pin_in,
    output logic [GPIO_DATA_WIDTH-1:0] n_gpio_pin_oe,
    output logic [GPIO_DATA_WIDTH-1:0] gpio_pin_out,
    output logic                       irq
);

    localparam int W = GPIO_DATA_WIDTH;

    logic [W-1:0]        dir_r, out_r, int_en_r, int_type_r, int_pol_r;
    logic [W-1:0]        int_status_r, status_next;
    logic [DB_CNT_W-1:0] db_thresh_r;
    logic [W-1:0]        stable, stable_q;
    logic [W-1:0]        w1c, edge_hit;
    logic [W-1:0]        wdata_w;
    logic [4:0]          addr;
    logic                wr_en, rd_en;
    logic                irq_r;
    logic                unused_bits;

    assign addr    = word_addr(apb.paddr);
    assign wr_en   = apb.psel & apb.penable & apb.pwrite;
    assign rd_en   = apb.psel & apb.penable & ~apb.pwrite;
    assign wdata_w = apb.pwdata[W-1:0];

    // Address byte-lane bits and pwdata bits above the bank width are don't-care.
    assign unused_bits = ^{apb.paddr[1:0], apb.pwdata};

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_pin
            gpio_pin_debounce #(
                .SYNC_STAGES (SYNC_STAGES),
                .DB_CNT_W    (DB_CNT_W)
            ) u_db (
                .clk    (pclk),
                .rst    (p_reset),
                .pin_in (gpio_pin_in[gi]),
                .thresh (db_thresh_r),
                .stable (stable[gi])
            );
        end
    endgenerate

    // Plain read/write configuration registers.
    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            dir_r       <= '0;
            out_r       <= '0;
            int_en_r    <= '0;
            int_type_r  <= '0;
            int_pol_r   <= '0;
            db_thresh_r <= '0;
        end else if (wr_en) begin
            case (addr)
                GPIO_DIR_ADDR:   dir_r       <= wdata_w;
                GPIO_OUT_ADDR:   out_r       <= wdata_w;
                GPIO_IEN_ADDR:   int_en_r    <= wdata_w;
                GPIO_ITYPE_ADDR: int_type_r  <= wdata_w;
                GPIO_IPOL_ADDR:  int_pol_r   <= wdata_w;
                GPIO_DBT_ADDR:   db_thresh_r <= apb.pwdata[DB_CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // Edge events from the debounced level and its one-cycle-old copy.
    always_comb begin
        w1c      = (wr_en && addr == GPIO_ISTAT_ADDR) ? wdata_w : '0;
        edge_hit = (stable & ~stable_q & ~int_pol_r) | (~stable & stable_q & int_pol_r);
    end

    // Next interrupt status: edge pins latch (a new event beats a clear),
    // level pins simply track the qualified level and ignore clears.
    always_comb begin
        status_next = int_status_r;
        for (int i = 0; i < W; i++) begin
            if (int_type_e'(int_type_r[i]) == INT_EDGE)
                status_next[i] = (int_status_r[i] & ~w1c[i]) | edge_hit[i];
            else
                status_next[i] = stable[i] ^ int_pol_r[i];
        end
    end

    // Status, delayed input copy and masked interrupt output.
    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            int_status_r <= '0;
            stable_q     <= '0;
            irq_r        <= 1'b0;
        end else begin
            int_status_r <= status_next;
            stable_q     <= stable;
            irq_r        <= |(int_status_r & int_en_r);
        end
    end

    // Read mux; the bus is driven only during a read access phase.
    always_comb begin
        apb.prdata = '0;
        if (rd_en) begin
            case (addr)
                GPIO_DIR_ADDR:   apb.prdata = 32'(dir_r);
                GPIO_OUT_ADDR:   apb.prdata = 32'(out_r);
                GPIO_IN_ADDR:    apb.prdata = 32'(stable);
                GPIO_IEN_ADDR:   apb.prdata = 32'(int_en_r);
                GPIO_ITYPE_ADDR: apb.prdata = 32'(int_type_r);
                GPIO_IPOL_ADDR:  apb.prdata = 32'(int_pol_r);
                GPIO_ISTAT_ADDR: apb.prdata = 32'(int_status_r);
                GPIO_DBT_ADDR:   apb.prdata = 32'(db_thresh_r);
                default:         apb.prdata = '0;
            endcase
        end
    end

    assign apb.pready    = 1'b1;
    assign n_gpio_pin_oe = ~dir_r;
    assign gpio_pin_out  = out_r;
    assign irq           = irq_r;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Scoreboard bench for gpio_bank_ctrl: stimulus queues expectations,
// a negedge monitor pops and compares whenever an output is presented.
module tb_gpio_bank_ctrl;
    import gpio_bank_pkg::*;

    localparam int W = 16;

    logic         pclk = 1'b0;
    logic         p_reset = 1'b1;
    logic [W-1:0] gpio_pin_in = '1;
    logic [W-1:0] n_oe, pin_out;
    logic         irq;

    gpio_bank_ctrl_if bus();

    gpio_bank_ctrl #(
        .GPIO_DATA_WIDTH (W),
        .SYNC_STAGES     (2),
        .DB_CNT_W        (8)
    ) dut (
        .pclk          (pclk),
        .p_reset       (p_reset),
        .apb           (bus),
        .gpio_pin_in   (gpio_pin_in),
        .n_gpio_pin_oe (n_oe),
        .gpio_pin_out  (pin_out),
        .irq           (irq)
    );

    always #5 pclk = ~pclk;

    // sel: 0 prdata, 1 n_gpio_pin_oe, 2 gpio_pin_out, 3 irq, 4 pready
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic probe    = 1'b0;
    int   probe_n  = 0;

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            1:       return 32'(n_oe);
            2:       return 32'(pin_out);
            3:       return 32'(irq);
            4:       return 32'(bus.pready);
            default: return bus.prdata;
        endcase
    endfunction

    // Monitor: a read access phase presents prdata; a probe presents the
    // queued pin/irq expectations for this cycle.
    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        int          n;
        forever begin
            @(negedge pclk);
            n = (bus.psel && bus.penable && !bus.pwrite) ? 1 : (probe ? probe_n : 0);
            for (int k = 0; k < n; k++) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got %h with nothing queued", bus.prdata);
                end else begin
                    e   = sb.pop_front();
                    act = (bus.psel && bus.penable && !bus.pwrite) ? bus.prdata : sample(e.sel);
                    if (act !== e.exp) begin
                        n_fail++;
                        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic push(input string nm, input int sel, input logic [31:0] ex);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.exp  = ex;
        sb.push_back(e);
    endtask

    // Check the queued probes at the coming negedge, without crossing a posedge.
    task automatic fire(input int n);
        probe_n = n;
        probe   = 1'b1;
        @(negedge pclk);
        #1;
        probe   = 1'b0;
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = a;
        bus.pwdata  = d;
        tick();
        bus.penable = 1'b1;
        tick();
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, input logic [31:0] ex, input string nm);
        push(nm, 0, ex);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = a;
        tick();
        bus.penable = 1'b1;
        tick();
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    initial begin : stimulus
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0;  bus.pwdata = '0;

        // 1. Reset values, then IN latency with pads high
        tick(2);
        push("rst_n_oe", 1, 32'h0000FFFF);
        push("rst_pin_out", 2, 32'h0);
        push("rst_irq", 3, 32'h0);
        push("rst_prdata", 0, 32'h0);
        push("pready", 4, 32'h1);
        fire(5);
        tick();
        p_reset = 1'b0;
        tick(1);
        apb_read(GPIO_IN_ADDR, 32'h0, "in_before_sync");
        apb_read(GPIO_IN_ADDR, 32'h0000FFFF, "in_after_sync");

        // 2. Direction and output data, upper bits ignored
        apb_write(GPIO_DIR_ADDR, 32'hFFFF_00F0);
        push("dir_n_oe", 1, 32'h0000FF0F);
        fire(1);
        apb_write(GPIO_OUT_ADDR, 32'h0000_00A5);
        push("out_pin", 2, 32'h000000A5);
        push("idle_prdata", 0, 32'h0);
        fire(2);
        apb_read(GPIO_DIR_ADDR, 32'h000000F0, "dir_readback");
        apb_read(GPIO_OUT_ADDR, 32'h000000A5, "out_readback");

        // 3. Debounce threshold, glitch rejection and exact latency
        gpio_pin_in = '0;
        tick(6);
        apb_write(GPIO_DBT_ADDR, 32'h0000_01FF);
        apb_read(GPIO_DBT_ADDR, 32'h000000FF, "dbt_width");
        apb_write(GPIO_DBT_ADDR, 32'h4);
        apb_read(GPIO_DBT_ADDR, 32'h4, "dbt_readback");
        gpio_pin_in[3] = 1'b1;
        tick(4);
        gpio_pin_in[3] = 1'b0;
        tick(12);
        apb_read(GPIO_IN_ADDR, 32'h0, "glitch_rejected");
        fork
            begin gpio_pin_in[3] = 1'b1; tick(6); gpio_pin_in[3] = 1'b0; end
            begin tick(5); apb_read(GPIO_IN_ADDR, 32'h0, "pulse_edge6"); end
        join
        tick(20);
        fork
            begin gpio_pin_in[3] = 1'b1; tick(6); gpio_pin_in[3] = 1'b0; end
            begin tick(6); apb_read(GPIO_IN_ADDR, 32'h8, "pulse_edge7"); end
        join
        tick(20);
        apb_read(GPIO_IN_ADDR, 32'h0, "pulse_released");

        // 4. Rising-edge interrupt on pin 5, W1C and set-beats-clear
        apb_write(GPIO_DBT_ADDR, 32'h0);
        apb_write(GPIO_ITYPE_ADDR, 32'h20);
        apb_write(GPIO_IPOL_ADDR, 32'h0);
        apb_write(GPIO_IEN_ADDR, 32'h20);
        apb_read(GPIO_ISTAT_ADDR, 32'h0, "stat_idle");
        gpio_pin_in[5] = 1'b1;
        tick(6);
        apb_read(GPIO_ISTAT_ADDR, 32'h20, "stat_rise");
        push("irq_rise", 3, 32'h1);
        fire(1);
        apb_write(GPIO_ISTAT_ADDR, 32'h20);
        push("irq_hold_after_w1c", 3, 32'h1);
        fire(1);
        tick();
        push("irq_cleared", 3, 32'h0);
        fire(1);
        apb_read(GPIO_ISTAT_ADDR, 32'h0, "stat_w1c");
        gpio_pin_in[5] = 1'b0;
        tick(8);
        apb_read(GPIO_ISTAT_ADDR, 32'h0, "stat_fall_ignored");
        gpio_pin_in[5] = 1'b1;
        tick(2);
        apb_write(GPIO_ISTAT_ADDR, 32'h20);
        apb_read(GPIO_ISTAT_ADDR, 32'h20, "set_beats_w1c");
        apb_write(GPIO_ISTAT_ADDR, 32'h20);
        apb_read(GPIO_ISTAT_ADDR, 32'h0, "stat_cleared_again");

        // 5. Active-low level interrupt on pin 0
        apb_write(GPIO_IPOL_ADDR, 32'h1);
        apb_write(GPIO_IEN_ADDR, 32'h1);
        apb_read(GPIO_ISTAT_ADDR, 32'h1, "level_low_set");
        apb_write(GPIO_ISTAT_ADDR, 32'h1);
        apb_read(GPIO_ISTAT_ADDR, 32'h1, "level_w1c_ignored");
        push("level_irq", 3, 32'h1);
        fire(1);
        tick();
        gpio_pin_in[0] = 1'b1;
        tick(4);
        push("level_irq_lag", 3, 32'h1);
        fire(1);
        tick();
        push("level_irq_fall", 3, 32'h0);
        fire(1);
        apb_read(GPIO_ISTAT_ADDR, 32'h0, "level_high_clear");

        // 6. Asynchronous reset mid-debounce with irq asserted
        gpio_pin_in[0] = 1'b0;
        tick(6);
        apb_write(GPIO_DBT_ADDR, 32'd10);
        gpio_pin_in[3] = 1'b1;
        tick(5);
        push("irq_before_reset", 3, 32'h1);
        fire(1);
        tick();
        p_reset = 1'b1;
        push("async_n_oe", 1, 32'h0000FFFF);
        push("async_pin_out", 2, 32'h0);
        push("async_irq", 3, 32'h0);
        fire(3);
        tick();
        p_reset = 1'b0;
        apb_read(GPIO_IN_ADDR, 32'h0, "in_after_reset");
        apb_read(GPIO_DIR_ADDR, 32'h0, "dir_after_reset");
        apb_read(GPIO_DBT_ADDR, 32'h0, "dbt_after_reset");
        apb_read(GPIO_IN_ADDR, 32'h28, "in_resettled");

        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
